// File: rtl/sms_pkg.sv
// rtl/sms_pkg.sv - shared constants and state encoding for the ROM loader
package sms_pkg;

    localparam int BANK_BYTES = 16384;
    localparam int MAX_BYTES  = 4194304;

    typedef logic [2:0] state_t;

    localparam state_t ST_SYNC     = 3'd0;
    localparam state_t ST_IDLE     = 3'd1;
    localparam state_t ST_LOAD     = 3'd2;
    localparam state_t ST_WAIT_ACK = 3'd3;
    localparam state_t ST_FINISH   = 3'd4;

endpackage

// File: rtl/rom_loader_if.sv
// rtl/rom_loader_if.sv - hps_io download and sdram write signals of the ROM loader
interface rom_loader_if;

    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [23:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_req;
    logic        ram_ack;

    modport master (
        input  ioctl_download, ioctl_wr, ioctl_dout, ram_ack,
        output ioctl_wait, ram_addr, ram_din, ram_req
    );

    modport slave (
        output ioctl_download, ioctl_wr, ioctl_dout, ram_ack,
        input  ioctl_wait, ram_addr, ram_din, ram_req
    );

endinterface

// File: rtl/bank_mask.sv
// rtl/bank_mask.sv - power-of-two bank mask from a downloaded byte count
module bank_mask
    import sms_pkg::*;
#(
    parameter int BANK_SIZE = BANK_BYTES
) (
    input  logic [22:0] count_i,
    input  logic        overflow_i,
    output logic [7:0]  mask_o
);

    localparam int SHIFT = $clog2(BANK_SIZE);

    logic [22:0] last_bank;
    logic [7:0]  smear;

    // ceil(count/bank)-1 == floor((count-1)/bank) for count >= 1
    always_comb begin
        last_bank = (count_i - 23'd1) >> SHIFT;
        smear     = last_bank[7:0];
        smear     = smear | (smear >> 1);
        smear     = smear | (smear >> 2);
        smear     = smear | (smear >> 4);
        if (overflow_i) begin
            mask_o = 8'hFF;
        end else if (count_i == 23'd0) begin
            mask_o = 8'h00;
        end else if (|last_bank[22:8]) begin
            mask_o = 8'hFF;
        end else begin
            mask_o = smear;
        end
    end

endmodule

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - streams an hps_io ROM download into sdram with a toggle handshake
module rom_loader
    import sms_pkg::*;
#(
    parameter int BANK_SIZE = BANK_BYTES,
    parameter int MAX_SIZE  = MAX_BYTES
) (
    input  logic           clk_sys,
    input  logic           reset,
    rom_loader_if.master   bus,
    output logic [7:0]     cart_mask,
    output logic           done,
    output logic           overflow
);

    localparam logic [22:0] MAX_CNT = 23'(MAX_SIZE);

    state_t      state_q, state_d;
    logic [22:0] cnt_q, cnt_d;
    logic [21:0] addr_q, addr_d;
    logic [7:0]  din_q, din_d;
    logic        req_q, req_d;
    logic        wait_q, wait_d;
    logic [7:0]  mask_q, mask_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic        dl_q;
    logic [7:0]  mask_calc;

    bank_mask #(.BANK_SIZE(BANK_SIZE)) u_bank_mask (
        .count_i    (cnt_q),
        .overflow_i (ovf_q),
        .mask_o     (mask_calc)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        din_d   = din_q;
        req_d   = req_q;
        wait_d  = wait_q;
        mask_d  = mask_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        case (state_q)
            ST_SYNC: begin
                wait_d = 1'b0;
                if (bus.ram_ack == req_q) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.ioctl_download && !dl_q) begin
                    cnt_d   = '0;
                    addr_d  = '0;
                    mask_d  = 8'h00;
                    ovf_d   = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!bus.ioctl_download) begin
                    state_d = ST_FINISH;
                end else if (bus.ioctl_wr) begin
                    if (cnt_q < MAX_CNT) begin
                        din_d   = bus.ioctl_dout;
                        req_d   = ~req_q;
                        wait_d  = 1'b1;
                        state_d = ST_WAIT_ACK;
                    end else begin
                        // past the image limit: keep counting so the host sees no stall
                        cnt_d = cnt_q + 23'd1;
                        ovf_d = 1'b1;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (bus.ioctl_wr) ovf_d = 1'b1;
                if (bus.ram_ack == req_q) begin
                    wait_d  = 1'b0;
                    addr_d  = addr_q + 22'd1;
                    cnt_d   = cnt_q + 23'd1;
                    state_d = bus.ioctl_download ? ST_LOAD : ST_FINISH;
                end
            end
            ST_FINISH: begin
                mask_d  = mask_calc;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= ST_SYNC;
            cnt_q   <= '0;
            addr_q  <= '0;
            din_q   <= 8'h00;
            req_q   <= 1'b0;
            wait_q  <= 1'b0;
            mask_q  <= 8'h00;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            req_q   <= req_d;
            wait_q  <= wait_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            dl_q    <= bus.ioctl_download;
        end
    end

    assign bus.ioctl_wait = wait_q;
    assign bus.ram_addr   = {2'b00, addr_q};
    assign bus.ram_din    = din_q;
    assign bus.ram_req    = req_q;
    assign cart_mask      = mask_q;
    assign done           = done_q;
    assign overflow       = ovf_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - directed bench for rom_loader with scaled bank and image sizes
module tb_rom_loader;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [7:0] cart_mask;
    logic       done;
    logic       overflow;

    always #5 clk_sys = ~clk_sys;

    rom_loader_if bus();

    // bank = 16 bytes, image limit = 64 bytes (4 banks)
    rom_loader #(.BANK_SIZE(16), .MAX_SIZE(64)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .bus       (bus),
        .cart_mask (cart_mask),
        .done      (done),
        .overflow  (overflow)
    );

    int   checks = 0;
    int   errors = 0;
    int   toggles = 0;
    int   done_cnt = 0;
    int   data_err = 0;
    int   last_addr = 0;
    int   lat_cnt = 0;
    int   ack_lat = 3;
    bit   hold_ack = 1'b0;
    bit   ack_clear = 1'b1;
    logic prev_req = 1'b0;

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 7 + 3);
    endfunction

    // sdram model and write monitor
    always @(negedge clk_sys) begin
        if (done) done_cnt++;
        if (bus.ram_req !== prev_req && !reset) begin
            if (bus.ram_din !== pat(toggles) || int'(bus.ram_addr) != toggles) data_err++;
            if (bus.ram_addr[23:22] !== 2'b00) data_err++;
            last_addr = int'(bus.ram_addr);
            toggles++;
        end
        prev_req = bus.ram_req;
        if (ack_clear) begin
            bus.ram_ack = 1'b0;
            lat_cnt = 0;
        end else if (!hold_ack && bus.ram_req !== bus.ram_ack) begin
            if (lat_cnt >= ack_lat - 1) begin
                bus.ram_ack = bus.ram_req;
                lat_cnt = 0;
            end else begin
                lat_cnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (bus.ioctl_wait !== 1'b0 && t < 200) begin
            @(negedge clk_sys);
            t++;
        end
        if (t >= 200) chk("wait_timeout", 32'(t), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_idle();
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_dout = b;
        @(negedge clk_sys);
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt == 0 && t < 200) begin
            @(negedge clk_sys);
            t++;
        end
        if (t >= 200) chk("done_timeout", 32'(done_cnt), 32'd1);
        repeat (5) @(negedge clk_sys);
    endtask

    task automatic start_dl();
        toggles  = 0;
        done_cnt = 0;
        data_err = 0;
        bus.ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic download(input int n);
        start_dl();
        for (int i = 0; i < n; i++) send_byte(pat(i));
        wait_idle();
        bus.ioctl_download = 1'b0;
        wait_done();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wait"}, 32'(bus.ioctl_wait), 32'd0);
        chk({tag, "_req"},  32'(bus.ram_req),    32'd0);
        chk({tag, "_addr"}, 32'(bus.ram_addr),   32'd0);
        chk({tag, "_din"},  32'(bus.ram_din),    32'd0);
        chk({tag, "_mask"}, 32'(cart_mask),      32'd0);
        chk({tag, "_done"}, 32'(done),           32'd0);
        chk({tag, "_ovf"},  32'(overflow),       32'd0);
    endtask

    task automatic chk_dl32(input string tag);
        chk({tag, "_toggles"}, 32'(toggles),   32'd32);
        chk({tag, "_lastadr"}, 32'(last_addr), 32'h1F);
        chk({tag, "_mask"},    32'(cart_mask), 32'h01);
        chk({tag, "_done"},    32'(done_cnt),  32'd1);
        chk({tag, "_ovf"},     32'(overflow),  32'd0);
        chk({tag, "_data"},    32'(data_err),  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int counts[5];
        logic [7:0] masks[5];
        int t0;
        counts = '{48, 17, 0, 16, 33};
        masks  = '{8'h03, 8'h01, 8'h00, 8'h00, 8'h03};

        reset = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr = 1'b0;
        bus.ioctl_dout = 8'h00;
        repeat (3) @(negedge clk_sys);
        chk_reset_vals("por");
        reset = 1'b0;
        ack_clear = 1'b0;
        repeat (3) @(negedge clk_sys);

        download(32);
        chk_dl32("dl32");
        chk("dl32_endaddr", 32'(bus.ram_addr), 32'h20);

        toggles = 0;
        bus.ioctl_wr = 1'b1;
        bus.ioctl_dout = 8'h5A;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        repeat (5) @(negedge clk_sys);
        chk("wr_outside_dl", 32'(toggles), 32'd0);
        chk("mask_stable", 32'(cart_mask), 32'h01);

        for (int k = 0; k < 5; k++) begin
            download(counts[k]);
            chk($sformatf("dl%0d_toggles", counts[k]), 32'(toggles), 32'(counts[k]));
            chk($sformatf("dl%0d_mask", counts[k]), 32'(cart_mask), 32'(masks[k]));
            chk($sformatf("dl%0d_done", counts[k]), 32'(done_cnt), 32'd1);
        end

        start_dl();
        send_byte(pat(0));
        chk("xtra_wait_hi", 32'(bus.ioctl_wait), 32'd1);
        bus.ioctl_wr = 1'b1;
        bus.ioctl_dout = 8'hEE;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        for (int i = 1; i < 4; i++) send_byte(pat(i));
        wait_idle();
        bus.ioctl_download = 1'b0;
        wait_done();
        chk("xtra_toggles", 32'(toggles), 32'd4);
        chk("xtra_ovf", 32'(overflow), 32'd1);
        chk("xtra_data", 32'(data_err), 32'd0);
        chk("xtra_mask", 32'(cart_mask), 32'hFF);

        download(65);
        chk("big_toggles", 32'(toggles), 32'd64);
        chk("big_ovf", 32'(overflow), 32'd1);
        chk("big_mask", 32'(cart_mask), 32'hFF);
        chk("big_data", 32'(data_err), 32'd0);

        // leave ram_req==ram_ack==1 so the held ack below is 1
        if (bus.ram_req == 1'b0) download(1);
        hold_ack = 1'b1;
        start_dl();
        send_byte(pat(0));
        repeat (2) @(negedge clk_sys);
        chk("prerst_wait", 32'(bus.ioctl_wait), 32'd1);
        chk("prerst_ack", 32'(bus.ram_ack), 32'd1);
        reset = 1'b1;
        bus.ioctl_download = 1'b0;
        @(negedge clk_sys);
        chk_reset_vals("midrst");
        reset = 1'b0;
        t0 = toggles;
        bus.ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
        bus.ioctl_wr = 1'b1;
        bus.ioctl_dout = 8'h11;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        repeat (5) @(negedge clk_sys);
        chk("sync_req", 32'(bus.ram_req), 32'd0);
        chk("sync_toggles", 32'(toggles), 32'(t0));
        chk("sync_wait", 32'(bus.ioctl_wait), 32'd0);
        bus.ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
        ack_clear = 1'b1;
        hold_ack = 1'b0;
        @(negedge clk_sys);
        ack_clear = 1'b0;
        repeat (3) @(negedge clk_sys);
        download(32);
        chk_dl32("postrst");

        start_dl();
        for (int i = 0; i < 16; i++) send_byte(pat(i));
        wait_idle();
        hold_ack = 1'b1;
        send_byte(pat(16));
        bus.ioctl_download = 1'b0;
        repeat (10) @(negedge clk_sys);
        chk("pend_nodone", 32'(done_cnt), 32'd0);
        chk("pend_wait", 32'(bus.ioctl_wait), 32'd1);
        hold_ack = 1'b0;
        wait_done();
        chk("pend_done", 32'(done_cnt), 32'd1);
        chk("pend_toggles", 32'(toggles), 32'd17);
        chk("pend_mask", 32'(cart_mask), 32'h01);
        chk("pend_ovf", 32'(overflow), 32'd0);
        chk("pend_data", 32'(data_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have clk_sys, input, 1, system clock; all logic on its rising edge.
REQ-002 SHALL have reset, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have ioctl_download, input, 1, high for the duration of a ROM transfer from hps_io.
REQ-004 SHALL have ioctl_wr, input, 1, one-cycle strobe marking a valid ioctl_dout byte.
REQ-005 SHALL have ioctl_dout, input, 8, download data byte.
REQ-006 SHALL have ioctl_wait, output, 1, stall request to hps_io.
REQ-007 SHALL have ram_addr, output, 24, SDRAM byte write address.
REQ-008 SHALL have ram_din, output, 8, SDRAM write data.
REQ-009 SHALL have ram_req, output, 1, toggle-type write request to sdram.
REQ-010 SHALL have ram_ack, input, 1, toggle-type write acknowledge from sdram.
REQ-011 SHALL have cart_mask, output, 8, 16 KB bank mask, power-of-two rounded.
REQ-012 SHALL have done, output, 1, one-cycle pulse when a download completes.
REQ-013 SHALL have overflow, output, 1, sticky flag: image exceeded 4 MB or a byte arrived while stalled.

Function
REQ-014 SHALL implement states SYNC, IDLE, LOAD, WAIT_ACK, FINISH.
REQ-015 SYNC: SHALL hold ioctl_wait=0 and go to IDLE on the first cycle in which ram_ack==ram_req.
REQ-016 IDLE: on the rising edge of ioctl_download, SHALL clear the byte counter, ram_addr, cart_mask and overflow, then enter LOAD.
REQ-017 LOAD: on ioctl_wr with counter<4194304, SHALL latch ram_din<=ioctl_dout, toggle ram_req, set ioctl_wait=1 and enter WAIT_ACK in the same cycle.
REQ-018 LOAD: on ioctl_wr with counter>=4194304, SHALL not write, SHALL still increment the counter, SHALL set overflow, and SHALL not raise ioctl_wait.
REQ-019 WAIT_ACK: when ram_ack==ram_req, SHALL clear ioctl_wait, increment ram_addr and the 23-bit counter, and return to LOAD; the latency from ioctl_wr to ioctl_wait falling is the sdram latency plus 1 cycle.
REQ-020 WAIT_ACK: an ioctl_wr SHALL be dropped and SHALL set overflow.
REQ-021 ioctl_download falling while in LOAD SHALL enter FINISH; while in WAIT_ACK, SHALL first complete the ack, then enter FINISH.
REQ-022 FINISH: SHALL compute cart_mask, pulse done for one cycle, and enter IDLE.
REQ-023 cart_mask computation:
- banks = ceil(count/16384);
- cart_mask = bitwise OR-smear toward the LSB of (banks-1), 8 bits;
- count=0 SHALL give 0x00;
- overflow SHALL force 0xFF.
REQ-024 cart_mask SHALL remain stable from FINISH until the next download starts.
REQ-025 ioctl_wr outside ioctl_download SHALL be ignored.
REQ-026 ram_addr[23:22] SHALL always be 0.

Reset
REQ-027 Reset SHALL force the following, regardless of state, including mid-transfer:
- state=SYNC;
- ioctl_wait=0, ram_req=0, ram_addr=0, ram_din=0;
- cart_mask=0x00, done=0, overflow=0, counter=0.
REQ-028 After reset, the block SHALL not issue ram_req until SYNC observes ram_ack==ram_req.

Structure
REQ-029 The state enumeration and constants BANK_BYTES=16384 and MAX_BYTES=4194304 SHALL live in a shared package, sms_pkg.
REQ-030 The mask computation SHALL be a separate combinational sub-module, bank_mask, with input 23-bit count plus overflow and output an 8-bit mask.

Verification
REQ-031 Scenario: 32768 bytes, ack 3 cycles after each req -> 32768 req toggles, last ram_addr=0x7FFF, cart_mask=0x01, one done pulse, overflow=0.
REQ-032 Scenario: 49152 bytes -> cart_mask=0x03; 16385 bytes -> cart_mask=0x01; 0 bytes -> cart_mask=0x00.
REQ-033 Scenario: extra ioctl_wr injected while ioctl_wait=1 -> byte not written, overflow=1, req count unchanged.
REQ-034 Scenario: 4194305 bytes -> exactly 4194304 writes, overflow=1, cart_mask=0xFF.
REQ-035 Scenario: reset asserted while in WAIT_ACK with ram_ack held at 1 -> all outputs at reset values; no new ram_req until ram_ack returns to 0; the next download then behaves as in REQ-031.
REQ-036 Scenario: ioctl_download falls while an ack is pending -> the ack is honoured, the counter includes that byte, and done pulses exactly once afterwards.
